// File: rtl/synth_pkg.sv
// Shared types for the wave sequencer: wave encodings, FSM states and pattern entry layout.
package synth_pkg;

  localparam logic [1:0] WAVE_SINE   = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_SAW    = 2'b10;

  localparam int DEF_INC_W = 16;
  localparam int DEF_DUR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seq_state_e;

  typedef struct packed {
    logic [1:0]           wave;
    logic [DEF_INC_W-1:0] inc;
    logic [DEF_DUR_W-1:0] dur;
  } seq_entry_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern table: one synchronous write port, one combinational read port, async clear.
module seq_pattern_ram #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WORD_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read is combinational so a same-cycle write is only seen on the following cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wave_sequencer.sv
// Note sequencer: walks the pattern table and drives wave type, phase increment and gate.
//   state | meaning
//   IDLE  | waiting for Start, gate low
//   LOAD  | read entry[idx], start a note or finish the pattern
//   PLAY  | gate high, duration counter running
//   GAP   | gate low between notes
module wave_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS      = 8,
  parameter int ADDR_W     = 3,
  parameter int INC_W      = 16,
  parameter int DUR_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Loop,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [1:0]        WrWaveType,
  input  logic [INC_W-1:0]  WrPhaseInc,
  input  logic [DUR_W-1:0]  WrDuration,
  output logic [1:0]        WaveType,
  output logic [INC_W-1:0]  PhaseInc,
  output logic              Gate,
  output logic [ADDR_W-1:0] StepIndex,
  output logic              StepStrobe,
  output logic              Busy,
  output logic              Done
);

  localparam int WORD_W = 2 + INC_W + DUR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STEPS - 1);

  seq_state_e        state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q, idx_nxt;
  logic              wrap_q, wrap_nxt;
  logic [DUR_W-1:0]  cnt_q, cnt_nxt;
  logic              latch_note;
  logic              strobe_nxt;
  logic              done_nxt;

  logic [WORD_W-1:0] rd_word;
  logic [1:0]        rd_wave;
  logic [INC_W-1:0]  rd_inc;
  logic [DUR_W-1:0]  rd_dur;

  assign {rd_wave, rd_inc, rd_dur} = rd_word;

  seq_pattern_ram #(
    .DEPTH  (STEPS),
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data ({WrWaveType, WrPhaseInc, WrDuration}),
    .rd_addr (idx_q),
    .rd_data (rd_word)
  );

  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    wrap_nxt   = wrap_q;
    cnt_nxt    = cnt_q;
    latch_note = 1'b0;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    if (Stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_nxt = ST_LOAD;
            idx_nxt   = '0;
            wrap_nxt  = 1'b0;
          end
        end
        ST_LOAD: begin
          if (wrap_q || rd_dur == '0) begin
            // An end found at idx 0 without wrapping is an empty pattern; never loop on it.
            if ((!wrap_q && idx_q == '0) || !Loop) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt  = '0;
              wrap_nxt = 1'b0;
            end
          end else begin
            latch_note = 1'b1;
            strobe_nxt = 1'b1;
            cnt_nxt    = rd_dur - 1'b1;
            state_nxt  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (cnt_q != '0) begin
            cnt_nxt = cnt_q - 1'b1;
          end else if (GAP_CYCLES > 0) begin
            cnt_nxt   = DUR_W'(GAP_CYCLES - 1);
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_LOAD;
            idx_nxt   = ADDR_W'(idx_q + 1'b1);
            wrap_nxt  = (idx_q == LAST_IDX);
          end
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_nxt = cnt_q - 1'b1;
          end else begin
            state_nxt = ST_LOAD;
            idx_nxt   = ADDR_W'(idx_q + 1'b1);
            wrap_nxt  = (idx_q == LAST_IDX);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      WaveType   <= '0;
      PhaseInc   <= '0;
      StepIndex  <= '0;
      StepStrobe <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      idx_q      <= idx_nxt;
      wrap_q     <= wrap_nxt;
      cnt_q      <= cnt_nxt;
      StepStrobe <= strobe_nxt;
      Done       <= done_nxt;
      // Note outputs change only when a new note is launched, so they hold through gaps.
      if (latch_note) begin
        WaveType  <= rd_wave;
        PhaseInc  <= rd_inc;
        StepIndex <= idx_q;
      end
    end
  end

  assign Gate = (state_q == ST_PLAY);
  assign Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: a note-level model predicts strobe/done events and gate lengths.
module tb_wave_sequencer;
  import synth_pkg::*;

  localparam int STEPS = 8;
  localparam int GAP   = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Stop  = 1'b0;
  logic        Loop  = 1'b0;
  logic        WrEn  = 1'b0;
  logic [2:0]  WrAddr = '0;
  logic [1:0]  WrWaveType = '0;
  logic [15:0] WrPhaseInc = '0;
  logic [15:0] WrDuration = '0;
  logic [1:0]  WaveType;
  logic [15:0] PhaseInc;
  logic        Gate;
  logic [2:0]  StepIndex;
  logic        StepStrobe;
  logic        Busy;
  logic        Done;

  wave_sequencer #(
    .STEPS(STEPS), .ADDR_W(3), .INC_W(16), .DUR_W(16), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Loop(Loop),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrWaveType(WrWaveType), .WrPhaseInc(WrPhaseInc),
    .WrDuration(WrDuration), .WaveType(WaveType), .PhaseInc(PhaseInc), .Gate(Gate),
    .StepIndex(StepIndex), .StepStrobe(StepStrobe), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          is_done;
    int          t;
    logic [1:0]  wave;
    logic [15:0] inc;
    int          idx;
    int          dur;
  } ev_t;

  ev_t        exp_q[$];
  seq_entry_t tbl[STEPS];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         ignore_gate = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Note-level model: a note of duration D starting at t is followed by the next event at t+D+GAP+1;
  // a loop restart costs one extra LOAD cycle.
  function automatic void build(input bit loop_en, input int t0, input int max_notes);
    int t = t0;
    int i = 0;
    int n = 0;
    ev_t e;
    for (int k = 0; k < 64; k++) begin
      if (i == STEPS || tbl[i].dur == 0) begin
        if (i == 0 || !loop_en) begin
          e.is_done = 1; e.t = t; e.wave = '0; e.inc = '0; e.idx = 0; e.dur = 0;
          exp_q.push_back(e);
          return;
        end
        t += 1;
        i = 0;
      end else begin
        e.is_done = 0; e.t = t; e.wave = tbl[i].wave; e.inc = tbl[i].inc;
        e.idx = i; e.dur = int'(tbl[i].dur);
        exp_q.push_back(e);
        n++;
        t += int'(tbl[i].dur) + GAP + 1;
        i++;
        if (loop_en && n >= max_notes) return;
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic write_entry(input int a, input logic [1:0] w, input logic [15:0] inc,
                             input logic [15:0] d);
    logic [2:0] a3;
    a3 = a[2:0];
    WrEn = 1'b1; WrAddr = a3; WrWaveType = w; WrPhaseInc = inc; WrDuration = d;
    @(negedge Clock);
    WrEn = 1'b0;
    tbl[a].wave = w; tbl[a].inc = inc; tbl[a].dur = d;
  endtask

  task automatic start_run(input bit loop_en);
    Loop = loop_en;
    build(loop_en, cyc + 2, 12);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge Clock);
    while ((exp_q.size() != 0 || Busy) && k < 3000) begin
      @(negedge Clock);
      k++;
    end
    if (k >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  // Monitor: pops an expected event whenever the DUT strobes a note or signals Done.
  initial begin
    int run = 0;
    int exp_len = 0;
    ev_t e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        run = 0;
      end else begin
        if (StepStrobe) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got note at step %0d expected none", StepIndex);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", e.is_done, 0);
            check("strobe_time", cyc, e.t);
            check("wave_type", WaveType, e.wave);
            check("phase_inc", PhaseInc, e.inc);
            check("step_index", StepIndex, e.idx);
            check("gate_at_strobe", Gate, 1);
            exp_len = e.dur;
          end
        end
        if (Done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got Done at cycle %0d expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", e.is_done, 1);
            check("done_time", cyc, e.t);
            check("gate_at_done", Gate, 0);
          end
        end
        if (Gate) run++;
        else if (run != 0) begin
          if (!ignore_gate) check("gate_len", run, exp_len);
          run = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  w;
    logic [15:0] d;
    int k;
    for (int i = 0; i < STEPS; i++) tbl[i] = '0;

    tick(3);
    check("rst_wave", WaveType, 0);
    check("rst_inc", PhaseInc, 0);
    check("rst_gate", Gate, 0);
    check("rst_index", StepIndex, 0);
    check("rst_strobe", StepStrobe, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b0;
    tick(2);

    // Two-note one-shot pattern
    write_entry(0, WAVE_SQUARE, 16'h0100, 16'd5);
    write_entry(1, WAVE_SAW, 16'h0200, 16'd3);
    write_entry(2, WAVE_SINE, 16'h0000, 16'd0);
    start_run(0);
    wait_idle("oneshot");

    // Same pattern looped, then stopped after four notes
    start_run(1);
    k = 0;
    while (exp_q.size() > 8 && k < 500) begin @(negedge Clock); k++; end
    check("loop_progress", exp_q.size() <= 8, 1);
    ignore_gate = 1;
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    check("stop_gate", Gate, 0);
    check("stop_busy", Busy, 0);
    exp_q.delete();
    tick(20);
    check("stop_stays_idle", Busy, 0);
    ignore_gate = 0;
    Loop = 1'b0;

    // Empty pattern: one LOAD cycle then Done
    write_entry(0, WAVE_SQUARE, 16'h0300, 16'd0);
    start_run(0);
    check("empty_busy_load", Busy, 1);
    @(negedge Clock);
    check("empty_busy_after", Busy, 0);
    wait_idle("empty");

    // Full table, every entry two cycles, ends on wrap
    for (int i = 0; i < STEPS; i++) begin
      w = 2'($urandom_range(0, 2));
      write_entry(i, w, 16'($urandom), 16'd2);
    end
    start_run(0);
    wait_idle("full8");

    // Start and Stop together: Stop wins
    Start = 1'b1; Stop = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Stop = 1'b0;
    check("startstop_busy", Busy, 0);
    tick(5);
    check("startstop_busy_later", Busy, 0);
    check("startstop_gate", Gate, 0);

    // Start while playing is ignored; rewriting the playing entry leaves outputs alone
    write_entry(0, WAVE_SAW, 16'h1234, 16'd6);
    write_entry(1, WAVE_SQUARE, 16'h0042, 16'd4);
    write_entry(2, WAVE_SINE, 16'h0000, 16'd0);
    start_run(0);
    @(negedge Clock);
    Start = 1'b1;
    write_entry(0, WAVE_SINE, 16'hBEEF, 16'd9);
    Start = 1'b0;
    check("hold_wave", WaveType, WAVE_SAW);
    check("hold_inc", PhaseInc, 16'h1234);
    wait_idle("restart");

    // Randomised one-shot patterns
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < STEPS; i++) begin
        w = 2'($urandom_range(0, 2));
        d = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
        write_entry(i, w, 16'($urandom), d);
      end
      start_run(0);
      wait_idle("random");
    end

    // Reset in the middle of a note
    write_entry(0, WAVE_SQUARE, 16'h0777, 16'd10);
    write_entry(1, WAVE_SINE, 16'h0000, 16'd0);
    start_run(0);
    tick(3);
    ignore_gate = 1;
    Reset = 1'b1;
    #1;
    check("rst_mid_gate", Gate, 0);
    check("rst_mid_busy", Busy, 0);
    check("rst_mid_wave", WaveType, 0);
    check("rst_mid_inc", PhaseInc, 0);
    check("rst_mid_index", StepIndex, 0);
    exp_q.delete();
    for (int i = 0; i < STEPS; i++) tbl[i] = '0;
    @(negedge Clock);
    Reset = 1'b0;
    tick(2);
    ignore_gate = 0;
    start_run(0);
    wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
